bram2_be_fwd: RTL and testbench

//  Single-clock true dual-port block RAM with per-byte write enables and an optional output pipeline stage.

---
 rtl/bram2_be_fwd_pkg.sv | 32 +++
 rtl/bram2_be_fwd_out_pipe.sv | 56 +++++
 rtl/bram2_be_fwd.sv | 129 ++++++++++++
 tb/tb_bram2_be_fwd.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bram2_be_fwd_pkg.sv
// Shared constants and helpers for the dual-port byte-enable BRAM.
package bram_pkg;

    // Mixed-port read-during-write selection values for MIXED_NEW.
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MAX_DW = 1024;
    localparam int MAX_NB = MAX_DW / 8;

    // Byte i of the result comes from new_w when be[i] is set, else from old_w.
    function automatic logic [MAX_DW-1:0] be_merge(input logic [MAX_DW-1:0] old_w,
                                                   input logic [MAX_DW-1:0] new_w,
                                                   input logic [MAX_NB-1:0] be);
        logic [MAX_DW-1:0] r;
        r = old_w;
        for (int i = 0; i < MAX_NB; i++) begin
            if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return r;
    endfunction

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/bram2_be_fwd_out_pipe.sv
// Per-port output register stage: one or two flops deep, data holds between loads.
module bram_out_pipe
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int PIPELINED  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic                  vld_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o
);

    logic [DATA_WIDTH-1:0] s1_q;
    logic                  s1_vld_q;

    // First stage: capture word on any access, valid only for reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= load_i & vld_i;
            if (load_i) s1_q <= data_i;
        end
    end

    if (PIPELINED != 0) begin : g_two
        logic [DATA_WIDTH-1:0] s2_q;
        logic                  s2_vld_q;
        logic                  s1_ld_q;

        // Second stage follows the first one cycle later, holding when nothing new arrived.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                s1_ld_q  <= 1'b0;
                s2_q     <= '0;
                s2_vld_q <= 1'b0;
            end else begin
                s1_ld_q  <= load_i;
                s2_vld_q <= s1_vld_q;
                if (s1_ld_q) s2_q <= s1_q;
            end
        end

        assign data_o  = s2_q;
        assign valid_o = s2_vld_q;
    end else begin : g_one
        assign data_o  = s1_q;
        assign valid_o = s1_vld_q;
    end

endmodule

// File: rtl/bram2_be_fwd.sv
// True dual-port BRAM with byte enables, write-first own port, selectable
// cross-port read-during-write, write-write merge (A wins) and collision flag.
module bram2_be_fwd
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter int MEMSIZE    = 256,
    parameter int PIPELINED  = 0,
    parameter int MIXED_NEW  = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    ena_i,
    input  logic [DATA_WIDTH/8-1:0] wea_i,
    input  logic [ADDR_WIDTH-1:0]   addra_i,
    input  logic [DATA_WIDTH-1:0]   dia_i,
    output logic [DATA_WIDTH-1:0]   doa_o,
    output logic                    doa_valid_o,
    input  logic                    enb_i,
    input  logic [DATA_WIDTH/8-1:0] web_i,
    input  logic [ADDR_WIDTH-1:0]   addrb_i,
    input  logic [DATA_WIDTH-1:0]   dib_i,
    output logic [DATA_WIDTH-1:0]   dob_o,
    output logic                    dob_valid_o,
    output logic                    collision_o
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (clog2(MEMSIZE) < 1) ? 1 : clog2(MEMSIZE);
    localparam logic [ADDR_WIDTH:0] MEMSIZE_L = MEMSIZE[ADDR_WIDTH:0];

    if (DATA_WIDTH % 8 != 0) begin : g_err_dw
        $error("bram2_be_fwd: DATA_WIDTH must be a multiple of 8");
    end
    if (DATA_WIDTH > MAX_DW) begin : g_err_max
        $error("bram2_be_fwd: DATA_WIDTH exceeds merge helper width");
    end
    if (MEMSIZE > (1 << ADDR_WIDTH)) begin : g_err_ms
        $error("bram2_be_fwd: MEMSIZE exceeds 2**ADDR_WIDTH");
    end

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] o,
                                                    input logic [DATA_WIDTH-1:0] n,
                                                    input logic [NB-1:0]         be);
        return DATA_WIDTH'(be_merge(MAX_DW'(o), MAX_DW'(n), MAX_NB'(be)));
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEMSIZE];

    logic                  a_in, b_in, a_we, b_we, a_wr, b_wr, same_addr;
    logic [IDX_W-1:0]      idx_a, idx_b;
    logic [DATA_WIDTH-1:0] old_a, old_b, both_w, wr_a, wr_b, out_a, out_b;
    logic                  collision_d, collision_q;

    // Address decode, byte merges, collision resolution and read-data forwarding.
    always_comb begin
        idx_a     = addra_i[IDX_W-1:0];
        idx_b     = addrb_i[IDX_W-1:0];
        a_in      = {1'b0, addra_i} < MEMSIZE_L;
        b_in      = {1'b0, addrb_i} < MEMSIZE_L;
        a_we      = ena_i & (|wea_i);
        b_we      = enb_i & (|web_i);
        a_wr      = a_we & a_in;
        b_wr      = b_we & b_in;
        same_addr = addra_i == addrb_i;
        old_a     = a_in ? mem[idx_a] : '0;
        old_b     = b_in ? mem[idx_b] : '0;
        // Apply B first, then A on top so A owns any overlapping bytes.
        both_w    = merge(merge(old_a, dib_i, web_i), dia_i, wea_i);
        wr_a      = (b_wr && same_addr) ? both_w : merge(old_a, dia_i, wea_i);
        wr_b      = (a_wr && same_addr) ? both_w : merge(old_b, dib_i, web_i);

        if (!a_in)                                           out_a = '0;
        else if (a_we)                                       out_a = wr_a;
        else if (b_wr && same_addr && MIXED_NEW == RDW_NEW)  out_a = wr_b;
        else                                                 out_a = old_a;

        if (!b_in)                                           out_b = '0;
        else if (b_we)                                       out_b = wr_b;
        else if (a_wr && same_addr && MIXED_NEW == RDW_NEW)  out_b = wr_a;
        else                                                 out_b = old_b;

        collision_d = a_wr & b_wr & same_addr;
    end

    // Array update; when both ports hit one address they store the same merged word.
    always_ff @(posedge clk_i) begin
        if (a_wr) mem[idx_a] <= wr_a;
        if (b_wr) mem[idx_b] <= wr_b;
    end

    // One-cycle collision pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) collision_q <= 1'b0;
        else         collision_q <= collision_d;
    end

    assign collision_o = collision_q;

    bram_out_pipe #(.DATA_WIDTH(DATA_WIDTH), .PIPELINED(PIPELINED)) u_pipe_a (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (ena_i),
        .vld_i  (~(|wea_i)),
        .data_i (out_a),
        .data_o (doa_o),
        .valid_o(doa_valid_o)
    );

    bram_out_pipe #(.DATA_WIDTH(DATA_WIDTH), .PIPELINED(PIPELINED)) u_pipe_b (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (enb_i),
        .vld_i  (~(|web_i)),
        .data_i (out_b),
        .data_o (dob_o),
        .valid_o(dob_valid_o)
    );

`ifndef SYNTHESIS
    // Simulation-only notice for accesses beyond the implemented depth.
    always_ff @(posedge clk_i) begin
        if (ena_i && !a_in) $display("bram2_be_fwd warning: port A address %0d beyond MEMSIZE %0d", addra_i, MEMSIZE);
        if (enb_i && !b_in) $display("bram2_be_fwd warning: port B address %0d beyond MEMSIZE %0d", addrb_i, MEMSIZE);
    end
`endif

endmodule

// File: tb/tb_bram2_be_fwd.sv
// Directed bench: d0 = MEMSIZE 200, latency 1, old-data mixed reads;
// d1 = MEMSIZE 256, latency 2, new-data mixed reads. Both share stimulus.
module tb_bram2_be_fwd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0, enb = 1'b0;
    logic [7:0]  wea = '0, web = '0;
    logic [7:0]  addra = '0, addrb = '0;
    logic [63:0] dia = '0, dib = '0;
    logic [63:0] doa0, dob0, doa1, dob1;
    logic        va0, vb0, va1, vb1, col0, col1;
    int          chk = 0;
    int          err = 0;

    always #5 clk = ~clk;

    bram2_be_fwd #(.ADDR_WIDTH(8), .DATA_WIDTH(64), .MEMSIZE(200), .PIPELINED(0), .MIXED_NEW(0)) d0 (
        .clk_i(clk), .rst_ni(rst_n),
        .ena_i(ena), .wea_i(wea), .addra_i(addra), .dia_i(dia), .doa_o(doa0), .doa_valid_o(va0),
        .enb_i(enb), .web_i(web), .addrb_i(addrb), .dib_i(dib), .dob_o(dob0), .dob_valid_o(vb0),
        .collision_o(col0));

    bram2_be_fwd #(.ADDR_WIDTH(8), .DATA_WIDTH(64), .MEMSIZE(256), .PIPELINED(1), .MIXED_NEW(1)) d1 (
        .clk_i(clk), .rst_ni(rst_n),
        .ena_i(ena), .wea_i(wea), .addra_i(addra), .dia_i(dia), .doa_o(doa1), .doa_valid_o(va1),
        .enb_i(enb), .web_i(web), .addrb_i(addrb), .dib_i(dib), .dob_o(dob1), .dob_valid_o(vb1),
        .collision_o(col1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic en, input logic [7:0] we, input logic [7:0] ad, input logic [63:0] d);
        ena = en; wea = we; addra = ad; dia = d;
    endtask

    task automatic set_b(input logic en, input logic [7:0] we, input logic [7:0] ad, input logic [63:0] d);
        enb = en; web = we; addrb = ad; dib = d;
    endtask

    task automatic idle();
        set_a(1'b0, 8'h00, 8'h00, 64'h0);
        set_b(1'b0, 8'h00, 8'h00, 64'h0);
    endtask

    task automatic test_reset();
        #12;
        chk++; if (doa0 !== 64'h0 || va0 !== 1'b0) begin err++; $display("FAIL rst_init_d0a: got %h/%b want 0/0", doa0, va0); end
        chk++; if (dob1 !== 64'h0 || vb1 !== 1'b0) begin err++; $display("FAIL rst_init_d1b: got %h/%b want 0/0", dob1, vb1); end
        chk++; if (col0 !== 1'b0 || col1 !== 1'b0) begin err++; $display("FAIL rst_init_col: got %b/%b want 0/0", col0, col1); end
        #1 rst_n = 1'b1;
        tick();
        set_a(1'b1, 8'hFF, 8'd0, 64'hCAFE_0000_0000_0001);
        tick();
        set_a(1'b1, 8'h00, 8'd0, 64'h0);
        tick();
        idle();
        chk++; if (va0 !== 1'b1) begin err++; $display("FAIL rst_pre_valid: got %b want 1", va0); end
        rst_n = 1'b0;
        #1;
        chk++; if (doa0 !== 64'h0 || va0 !== 1'b0) begin err++; $display("FAIL rst_mid_d0a: got %h/%b want 0/0", doa0, va0); end
        chk++; if (doa1 !== 64'h0 || va1 !== 1'b0) begin err++; $display("FAIL rst_mid_d1a: got %h/%b want 0/0", doa1, va1); end
        #2 rst_n = 1'b1;
        tick();
        chk++; if (va0 !== 1'b0 || va1 !== 1'b0) begin err++; $display("FAIL rst_post1_valid: got %b/%b want 0/0", va0, va1); end
        tick();
        chk++; if (va1 !== 1'b0 || doa1 !== 64'h0) begin err++; $display("FAIL rst_post2_d1a: got %h/%b want 0/0", doa1, va1); end
    endtask

    task automatic test_byte_enable();
        set_a(1'b1, 8'hFF, 8'd3, 64'hAAAA_BBBB_CCCC_DDDD);
        tick();
        set_a(1'b1, 8'h0F, 8'd3, 64'h1111_2222_3333_4444);
        tick();
        chk++; if (doa0 !== 64'hAAAA_BBBB_3333_4444 || va0 !== 1'b0) begin err++; $display("FAIL be_writefirst: got %h/%b want aaaabbbb33334444/0", doa0, va0); end
        set_a(1'b1, 8'h00, 8'd3, 64'h0);
        tick();
        idle();
        chk++; if (doa0 !== 64'hAAAA_BBBB_3333_4444 || va0 !== 1'b1) begin err++; $display("FAIL be_read_d0: got %h/%b want aaaabbbb33334444/1", doa0, va0); end
        chk++; if (va1 !== 1'b0) begin err++; $display("FAIL be_d1_early: got %b want 0", va1); end
        tick();
        chk++; if (doa1 !== 64'hAAAA_BBBB_3333_4444 || va1 !== 1'b1) begin err++; $display("FAIL be_read_d1: got %h/%b want aaaabbbb33334444/1", doa1, va1); end
        chk++; if (doa0 !== 64'hAAAA_BBBB_3333_4444 || va0 !== 1'b0) begin err++; $display("FAIL be_hold_d0: got %h/%b want aaaabbbb33334444/0", doa0, va0); end
    endtask

    task automatic test_latency();
        logic [63:0] vv [3];
        vv[0] = 64'h0123_4567_89AB_CDEF;
        vv[1] = 64'hFEDC_BA98_7654_3210;
        vv[2] = 64'h0F0F_0F0F_F0F0_F0F0;
        set_a(1'b1, 8'hFF, 8'd0, vv[0]);
        set_b(1'b1, 8'hFF, 8'd1, vv[1]);
        tick();
        set_a(1'b1, 8'hFF, 8'd2, vv[2]);
        set_b(1'b0, 8'h00, 8'd0, 64'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_a(1'b1, 8'h00, 8'(i), 64'h0);
            tick();
            chk++; if (doa0 !== vv[i] || va0 !== 1'b1) begin err++; $display("FAIL lat_d0_%0d: got %h/%b want %h/1", i, doa0, va0, vv[i]); end
            if (i == 0) begin
                chk++; if (va1 !== 1'b0) begin err++; $display("FAIL lat_d1_0: got valid %b want 0", va1); end
            end else begin
                chk++; if (doa1 !== vv[i-1] || va1 !== 1'b1) begin err++; $display("FAIL lat_d1_%0d: got %h/%b want %h/1", i, doa1, va1, vv[i-1]); end
            end
        end
        idle();
        tick();
        chk++; if (doa1 !== vv[2] || va1 !== 1'b1 || va0 !== 1'b0) begin err++; $display("FAIL lat_tail: got %h/%b d0v %b want %h/1 0", doa1, va1, va0, vv[2]); end
        tick();
        chk++; if (doa1 !== vv[2] || va1 !== 1'b0) begin err++; $display("FAIL lat_hold_d1: got %h/%b want %h/0", doa1, va1, vv[2]); end
    endtask

    task automatic test_mixed();
        set_a(1'b1, 8'hFF, 8'd7, 64'h9);
        tick();
        set_a(1'b1, 8'h00, 8'd7, 64'h0);
        set_b(1'b1, 8'hFF, 8'd7, 64'h5);
        tick();
        idle();
        chk++; if (doa0 !== 64'h9 || va0 !== 1'b1) begin err++; $display("FAIL mix_old_a: got %h/%b want 9/1", doa0, va0); end
        chk++; if (dob0 !== 64'h5 || vb0 !== 1'b0) begin err++; $display("FAIL mix_wr_b: got %h/%b want 5/0", dob0, vb0); end
        chk++; if (col0 !== 1'b0) begin err++; $display("FAIL mix_nocol: got %b want 0", col0); end
        tick();
        chk++; if (doa1 !== 64'h5 || va1 !== 1'b1) begin err++; $display("FAIL mix_new_a: got %h/%b want 5/1", doa1, va1); end
        // Reverse direction: A writes byte 0 only while B reads.
        set_a(1'b1, 8'h01, 8'd7, 64'h77);
        set_b(1'b1, 8'h00, 8'd7, 64'h0);
        tick();
        idle();
        chk++; if (dob0 !== 64'h5 || vb0 !== 1'b1) begin err++; $display("FAIL mix_old_b: got %h/%b want 5/1", dob0, vb0); end
        tick();
        chk++; if (dob1 !== 64'h77 || vb1 !== 1'b1) begin err++; $display("FAIL mix_new_b: got %h/%b want 77/1", dob1, vb1); end
    endtask

    task automatic test_collision();
        set_a(1'b1, 8'hFF, 8'd4, 64'h1);
        set_b(1'b1, 8'hF0, 8'd4, 64'h2);
        tick();
        idle();
        chk++; if (col0 !== 1'b1 || col1 !== 1'b1) begin err++; $display("FAIL col1_pulse: got %b/%b want 1/1", col0, col1); end
        chk++; if (doa0 !== 64'h1 || dob0 !== 64'h1) begin err++; $display("FAIL col1_do: got %h/%h want 1/1", doa0, dob0); end
        tick();
        chk++; if (col0 !== 1'b0 || col1 !== 1'b0) begin err++; $display("FAIL col1_once: got %b/%b want 0/0", col0, col1); end
        set_a(1'b1, 8'h00, 8'd4, 64'h0);
        tick();
        idle();
        chk++; if (doa0 !== 64'h1) begin err++; $display("FAIL col1_mem: got %h want 1", doa0); end
        set_a(1'b1, 8'h0F, 8'd4, 64'h3333_3333_4444_4444);
        set_b(1'b1, 8'hF0, 8'd4, 64'h5555_5555_6666_6666);
        tick();
        idle();
        chk++; if (col0 !== 1'b1) begin err++; $display("FAIL col2_pulse: got %b want 1", col0); end
        chk++; if (doa0 !== 64'h5555_5555_4444_4444 || dob0 !== 64'h5555_5555_4444_4444) begin err++; $display("FAIL col2_do: got %h/%h want 5555555544444444", doa0, dob0); end
        // Both ports read one address: same word, no collision.
        set_a(1'b1, 8'h00, 8'd4, 64'h0);
        set_b(1'b1, 8'h00, 8'd4, 64'h0);
        tick();
        idle();
        chk++; if (doa0 !== 64'h5555_5555_4444_4444 || dob0 !== 64'h5555_5555_4444_4444 || va0 !== 1'b1 || vb0 !== 1'b1) begin err++; $display("FAIL dualrd: got %h/%h %b%b want 5555555544444444 11", doa0, dob0, va0, vb0); end
        chk++; if (col0 !== 1'b0) begin err++; $display("FAIL dualrd_col: got %b want 0", col0); end
    endtask

    task automatic test_out_of_range();
        set_a(1'b1, 8'hFF, 8'd50, 64'hDEAD_BEEF_0000_0050);
        tick();
        set_a(1'b1, 8'h00, 8'd250, 64'h0);
        tick();
        chk++; if (doa0 !== 64'h0 || va0 !== 1'b1) begin err++; $display("FAIL oor_read: got %h/%b want 0/1", doa0, va0); end
        set_a(1'b1, 8'hFF, 8'd250, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk++; if (va0 !== 1'b0) begin err++; $display("FAIL oor_wr_valid: got %b want 0", va0); end
        set_a(1'b1, 8'h00, 8'd50, 64'h0);
        set_b(1'b1, 8'h00, 8'd4, 64'h0);
        tick();
        chk++; if (doa0 !== 64'hDEAD_BEEF_0000_0050 || dob0 !== 64'h5555_5555_4444_4444) begin err++; $display("FAIL oor_keep1: got %h/%h want deadbeef00000050/5555555544444444", doa0, dob0); end
        set_a(1'b1, 8'h00, 8'd7, 64'h0);
        set_b(1'b1, 8'h00, 8'd3, 64'h0);
        tick();
        chk++; if (doa0 !== 64'h77 || dob0 !== 64'hAAAA_BBBB_3333_4444) begin err++; $display("FAIL oor_keep2: got %h/%h want 77/aaaabbbb33334444", doa0, dob0); end
        set_a(1'b1, 8'h00, 8'd199, 64'h0);
        idle();
        set_a(1'b1, 8'hFF, 8'd199, 64'h1990);
        tick();
        set_a(1'b1, 8'h00, 8'd199, 64'h0);
        tick();
        idle();
        chk++; if (doa0 !== 64'h1990 || va0 !== 1'b1) begin err++; $display("FAIL last_word: got %h/%b want 1990/1", doa0, va0); end
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_latency();
        test_mixed();
        test_collision();
        test_out_of_range();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

endmodule
